// File: rtl/psum_accum_unit.sv
// rtl/psum_accum_unit.sv - multi-pass psum accumulator with saturation, optional ReLU and handshaked drain
// Accumulates NPASS passes of col-lane psum vectors into a DEPTH-entry buffer, then streams results out.
module psum_accum_unit #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int DEPTH   = 16,
  parameter int PASS_W  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [PASS_W-1:0]           cfg_npass,
  input  logic [$clog2(DEPTH):0]      cfg_nent,
  input  logic                        cfg_relu,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [psum_bw*col-1:0]      in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [psum_bw*col-1:0]      out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        sat_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int VW = psum_bw * col;
  localparam logic [NW-1:0]      ONE_N  = NW'(1);
  localparam logic [PASS_W-1:0]  ONE_P  = PASS_W'(1);
  localparam logic [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t              state;
  logic [PASS_W-1:0]   npass_q;
  logic [PASS_W-1:0]   pass_q;
  logic [NW-1:0]       nent_q;
  logic                relu_q;
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [VW-1:0]       mem [DEPTH];

  logic                cfg_ok;
  logic                xfer;
  logic                last_ent;
  logic                last_pass;
  logic                last_rd;
  logic [AW-1:0]       rd_next;
  logic [VW-1:0]       cur_vec;
  logic [VW-1:0]       acc_vec;
  logic                lane_sat;

  assign cfg_ok    = (cfg_npass != '0) && (cfg_nent != '0) && (cfg_nent <= NW'(DEPTH));
  assign xfer      = in_valid && in_ready;
  assign last_ent  = ({1'b0, wptr} == (nent_q - ONE_N));
  assign last_pass = (pass_q == (npass_q - ONE_P));
  assign last_rd   = ({1'b0, rptr} == (nent_q - ONE_N));
  assign rd_next   = rptr + AW'(1);
  assign cur_vec   = mem[wptr];

  function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v, input logic en);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < col; i++) begin
      if (en && v[psum_bw*(i+1)-1]) r[i*psum_bw +: psum_bw] = '0;
    end
    return r;
  endfunction

  // The first pass overwrites so nothing from a previous job can leak into the sum.
  always_comb begin
    logic [psum_bw-1:0] a;
    logic [psum_bw-1:0] b;
    logic [psum_bw:0]   s;
    logic               ovf;
    acc_vec  = '0;
    lane_sat = 1'b0;
    for (int i = 0; i < col; i++) begin
      a   = cur_vec[i*psum_bw +: psum_bw];
      b   = in_data[i*psum_bw +: psum_bw];
      s   = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      ovf = s[psum_bw] ^ s[psum_bw-1];
      if (pass_q == '0) begin
        acc_vec[i*psum_bw +: psum_bw] = b;
      end else begin
        acc_vec[i*psum_bw +: psum_bw] = ovf ? (s[psum_bw] ? SAT_MIN : SAT_MAX) : s[psum_bw-1:0];
        if (ovf) lane_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[wptr] <= acc_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      npass_q   <= '0;
      pass_q    <= '0;
      nent_q    <= '0;
      relu_q    <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            npass_q  <= cfg_npass;
            nent_q   <= cfg_nent;
            relu_q   <= cfg_relu;
            wptr     <= '0;
            pass_q   <= '0;
            sat_flag <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            if (lane_sat) sat_flag <= 1'b1;
            if (last_ent) begin
              wptr <= '0;
              if (last_pass) begin
                // Entry 0 is still being written when nent==1, so bypass the fresh sum.
                state     <= DRAIN;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                rptr      <= '0;
                out_data  <= relu_vec((wptr == '0) ? acc_vec : mem[0], relu_q);
              end else begin
                pass_q <= pass_q + ONE_P;
              end
            end else begin
              wptr <= wptr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_rd) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              rptr     <= rd_next;
              out_data <= relu_vec(mem[rd_next], relu_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_unit.sv
// tb/tb_psum_accum_unit.sv - randomized and directed bench for psum_accum_unit against a behavioural model
module tb_psum_accum_unit;
  localparam int COL = 8;
  localparam int BW = 16;
  localparam int DEPTH = 16;
  localparam int PW = 4;
  localparam int NW = 5;
  localparam int VW = COL * BW;

  logic clk = 1'b0;
  logic reset, start, cfg_relu, in_valid, in_ready, out_valid, out_ready, busy, done, sat_flag;
  logic [PW-1:0] cfg_npass;
  logic [NW-1:0] cfg_nent;
  logic [VW-1:0] in_data, out_data;

  psum_accum_unit #(.col(COL), .psum_bw(BW), .DEPTH(DEPTH), .PASS_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_npass(cfg_npass), .cfg_nent(cfg_nent),
    .cfg_relu(cfg_relu), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got_log[$];
  logic exp_sat = 1'b0;
  bit expect_done = 0;
  bit prev_stall = 0;
  logic [VW-1:0] prev_data;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
      expect_done = 0;
    end else begin
      check("done", VW'(done), VW'(expect_done));
      if (done) begin
        check("sat_flag", VW'(sat_flag), VW'(exp_sat));
        check("leftover", VW'(exp_q.size()), '0);
      end
      expect_done = 0;
      if (prev_stall) begin
        check("hold_valid", VW'(out_valid), VW'(1));
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", VW'(1), VW'(0));
        end else begin
          check("out_data", out_data, exp_q.pop_front());
          got_log.push_back(out_data);
          if (exp_q.size() == 0) expect_done = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  function automatic logic [BW-1:0] gen_lane(input int mode, input int lane, input int e);
    case (mode)
      1: return BW'(e);
      2: return 16'hFFFB;
      3: if (lane == 0) return 16'h7000; else if (lane == 1) return 16'h9000; else return BW'($urandom);
      default: return $urandom_range(0, 1) ? BW'($urandom) : BW'($urandom_range(0, 400) - 200);
    endcase
  endfunction

  task automatic run_job(input int np, input int ne, input bit relu, input int mode,
                         input int rmode, input bit drain_start);
    logic [VW-1:0] beats[$];
    logic [VW-1:0] v;
    logic signed [BW-1:0] x;
    int acc, idx, cyc;
    bit seen;
    for (int p = 0; p < np; p++)
      for (int e = 0; e < ne; e++) begin
        for (int l = 0; l < COL; l++) v[l*BW +: BW] = gen_lane(mode, l, e);
        beats.push_back(v);
      end
    exp_sat = 1'b0;
    for (int e = 0; e < ne; e++) begin
      for (int l = 0; l < COL; l++) begin
        acc = 0;
        for (int p = 0; p < np; p++) begin
          x = beats[p*ne + e][l*BW +: BW];
          acc = (p == 0) ? int'(x) : acc + int'(x);
          if (acc > 32767) begin acc = 32767; exp_sat = 1'b1; end
          if (acc < -32768) begin acc = -32768; exp_sat = 1'b1; end
        end
        if (relu && acc < 0) acc = 0;
        v[l*BW +: BW] = BW'(acc);
      end
      exp_q.push_back(v);
    end
    got_log.delete();
    rdy_mode = rmode;
    @(posedge clk); #1;
    cfg_npass = PW'(np); cfg_nent = NW'(ne); cfg_relu = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < np*ne && cyc < 5000) begin
      in_valid = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data = beats[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < np*ne) check("accept_timeout", VW'(idx), VW'(np*ne));
    check("in_ready_drop", VW'(in_ready), VW'(0));
    check("first_valid", VW'(out_valid), VW'(1));
    in_valid = 1'($urandom); in_data = {4{$urandom}};
    if (drain_start) begin
      cfg_npass = 1; cfg_nent = 2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", VW'(0), VW'(1));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_after_done", VW'(busy), VW'(0));
  endtask

  task automatic try_illegal(input int np, input int ne);
    @(posedge clk); #1;
    cfg_npass = PW'(np); cfg_nent = NW'(ne); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("illegal_busy", VW'(busy), VW'(0));
      check("illegal_in_ready", VW'(in_ready), VW'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_npass = '0; cfg_nent = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_flags", VW'({busy, done, sat_flag, in_ready, out_valid}), '0);
    reset = 1'b0;

    // Single pass, lanes = entry index.
    run_job(1, 4, 0, 1, 0, 0);
    check("t1_count", VW'(got_log.size()), VW'(4));
    for (int k = 0; k < 4 && k < got_log.size(); k++) check("t1_lit", got_log[k], {COL{BW'(k)}});
    check("t1_sat", VW'(sat_flag), VW'(0));

    run_job(3, 2, 1, 2, 0, 0);
    for (int k = 0; k < 2 && k < got_log.size(); k++) check("t2_relu_lit", got_log[k], '0);
    run_job(3, 2, 0, 2, 0, 0);
    for (int k = 0; k < 2 && k < got_log.size(); k++) check("t2_raw_lit", got_log[k], {COL{16'hFFF1}});

    run_job(2, 1, 0, 3, 0, 0);
    if (got_log.size() > 0) begin
      check("t3_lane0", VW'(got_log[0][15:0]), VW'(16'h7FFF));
      check("t3_lane1", VW'(got_log[0][31:16]), VW'(16'h8000));
    end
    check("t3_sat", VW'(sat_flag), VW'(1));

    // Backpressure with a start pulse during drain.
    run_job(2, DEPTH, 0, 0, 1, 1);
    check("t4_count", VW'(got_log.size()), VW'(DEPTH));

    // Abort mid-accumulation, pass 1 of 3.
    rdy_mode = 0;
    @(posedge clk); #1;
    cfg_npass = 3; cfg_nent = 4; cfg_relu = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      in_data = {4{$urandom}};
      @(posedge clk); #1;
    end
    #2; reset = 1'b1; #1;
    check("abort_flags", VW'({busy, in_ready, out_valid, done}), '0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_job(3, 4, 0, 0, 0, 0);

    try_illegal(1, 0);
    try_illegal(1, 17);
    try_illegal(0, 4);

    for (int j = 0; j < 6; j++)
      run_job($urandom_range(1, 4), $urandom_range(1, DEPTH), 1'($urandom_range(0, 1)), 0, 2, 0);
    run_job(15, DEPTH, 1, 0, 2, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
